// File: rtl/accumulator_bank.sv
// Multi-channel burst accumulator: sums unsigned samples per channel and emits
// the total through a one-deep output register on burst end or in_last.
module accumulator_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 40,
    parameter int NUM_CH     = 4,
    parameter int BURST_LEN  = 8,
    parameter int SATURATE   = 0,
    localparam int CH_W      = $clog2(NUM_CH),
    localparam int CNT_W     = $clog2(BURST_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CH_W-1:0]       in_ch,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_data,
    output logic [CH_W-1:0]       out_ch,
    output logic [CNT_W-1:0]      out_count,
    output logic                  out_ovf
);

    logic [ACC_WIDTH-1:0] acc_q [NUM_CH];
    logic [ACC_WIDTH-1:0] acc_d [NUM_CH];
    logic [CNT_W-1:0]     cnt_q [NUM_CH];
    logic [CNT_W-1:0]     cnt_d [NUM_CH];
    logic [NUM_CH-1:0]    ovf_q, ovf_d;

    logic                 out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
    logic [CH_W-1:0]      out_ch_q, out_ch_d;
    logic [CNT_W-1:0]     out_count_q, out_count_d;
    logic                 out_ovf_q, out_ovf_d;

    logic                 accept, ch_ok, emit, overflow;
    logic [CH_W-1:0]      idx;
    logic [ACC_WIDTH:0]   sum_wide;
    logic [ACC_WIDTH-1:0] sum;
    logic [CNT_W-1:0]     cnt_inc;

    // Carry out of the accumulator either clamps to all-ones or wraps.
    function automatic logic [ACC_WIDTH-1:0] sat_sum(input logic [ACC_WIDTH:0] wide);
        if (wide[ACC_WIDTH] && (SATURATE != 0)) begin
            return '1;
        end
        return wide[ACC_WIDTH-1:0];
    endfunction

    assign in_ready = !clr && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    // Out-of-range channels are swallowed; idx is forced to 0 so the read stays in bounds.
    assign ch_ok    = {1'b0, in_ch} < (CH_W + 1)'(NUM_CH);
    assign idx      = ch_ok ? in_ch : '0;
    assign sum_wide = {1'b0, acc_q[idx]} + (ACC_WIDTH + 1)'(in_data);
    assign overflow = sum_wide[ACC_WIDTH];
    assign sum      = sat_sum(sum_wide);
    assign cnt_inc  = cnt_q[idx] + CNT_W'(1);
    assign emit     = accept && ch_ok && ((cnt_inc == CNT_W'(BURST_LEN)) || in_last);

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        if (emit) begin
            out_valid_d = 1'b1;
            out_data_d  = sum;
            out_ch_d    = in_ch;
            out_count_d = cnt_inc;
            out_ovf_d   = ovf_q[idx] | overflow;
            acc_d[idx]  = '0;
            cnt_d[idx]  = '0;
            ovf_d[idx]  = 1'b0;
        end else if (accept && ch_ok) begin
            acc_d[idx]  = sum;
            cnt_d[idx]  = cnt_inc;
            ovf_d[idx]  = ovf_q[idx] | overflow;
        end

        // in_ready is low during clr, so no accept can race the clear.
        if (clr) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_d[i] = '0;
                cnt_d[i] = '0;
            end
            ovf_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            ovf_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_accumulator_bank.sv
// Bench for accumulator_bank: three configurations share one stimulus stream
// (default, 8-bit wrap with 3 channels, 8-bit clamp with 3 channels).
module tb_accumulator_bank;

    logic        clk = 1'b0;
    logic        rst, clr, in_valid, in_last, out_ready;
    logic [31:0] in_data;
    logic [1:0]  in_ch;

    logic        rdy0, rdy1, rdy2, vld0, vld1, vld2, ovf0, ovf1, ovf2;
    logic [39:0] data0;
    logic [7:0]  data1, data2;
    logic [1:0]  ch0, ch1, ch2;
    logic [3:0]  cnt0, cnt1, cnt2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    accumulator_bank u_def (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy0),
        .in_data(in_data), .in_ch(in_ch), .in_last(in_last), .out_valid(vld0),
        .out_ready(out_ready), .out_data(data0), .out_ch(ch0), .out_count(cnt0),
        .out_ovf(ovf0)
    );

    accumulator_bank #(.DATA_WIDTH(8), .ACC_WIDTH(8), .NUM_CH(3), .BURST_LEN(8), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data[7:0]), .in_ch(in_ch), .in_last(in_last), .out_valid(vld1),
        .out_ready(out_ready), .out_data(data1), .out_ch(ch1), .out_count(cnt1),
        .out_ovf(ovf1)
    );

    accumulator_bank #(.DATA_WIDTH(8), .ACC_WIDTH(8), .NUM_CH(3), .BURST_LEN(8), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy2),
        .in_data(in_data[7:0]), .in_ch(in_ch), .in_last(in_last), .out_valid(vld2),
        .out_ready(out_ready), .out_data(data2), .out_ch(ch2), .out_count(cnt2),
        .out_ovf(ovf2)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Behavioural model: per configuration, per channel running sum and count.
    int     DW  [3] = '{32, 8, 8};
    int     AW  [3] = '{40, 8, 8};
    int     NC  [3] = '{4, 3, 3};
    int     SAT [3] = '{0, 0, 1};
    longint macc [3][4];
    int     mcnt [3][4];
    bit     movf [3][4];
    bit     mov  [3];
    longint mod  [3];
    int     moch [3];
    int     mocnt[3];
    bit     moovf[3];

    initial begin
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 4; c++) begin
                macc[k][c] = 0; mcnt[k][c] = 0; movf[k][c] = 0;
            end
            mov[k] = 0; mod[k] = 0; moch[k] = 0; mocnt[k] = 0; moovf[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                logic        g_rdy, g_vld, g_ovf;
                logic [63:0] g_data, g_ch, g_cnt;
                longint      amask, dmask, s;
                bit          m_rdy, o;
                int          c;
                case (k)
                    0: begin g_rdy = rdy0; g_vld = vld0; g_ovf = ovf0; g_data = 64'(data0); g_ch = 64'(ch0); g_cnt = 64'(cnt0); end
                    1: begin g_rdy = rdy1; g_vld = vld1; g_ovf = ovf1; g_data = 64'(data1); g_ch = 64'(ch1); g_cnt = 64'(cnt1); end
                    default: begin g_rdy = rdy2; g_vld = vld2; g_ovf = ovf2; g_data = 64'(data2); g_ch = 64'(ch2); g_cnt = 64'(cnt2); end
                endcase
                amask = (longint'(1) << AW[k]) - 1;
                dmask = (longint'(1) << DW[k]) - 1;
                m_rdy = !clr && (!mov[k] || out_ready);

                chk($sformatf("in_ready[%0d]", k), 64'(g_rdy), 64'(m_rdy));
                chk($sformatf("out_valid[%0d]", k), 64'(g_vld), 64'(mov[k]));
                if (mov[k]) begin
                    chk($sformatf("out_data[%0d]", k), g_data, mod[k]);
                    chk($sformatf("out_ch[%0d]", k), g_ch, moch[k]);
                    chk($sformatf("out_count[%0d]", k), g_cnt, mocnt[k]);
                    chk($sformatf("out_ovf[%0d]", k), 64'(g_ovf), 64'(moovf[k]));
                end

                if (rst) begin
                    for (int i = 0; i < 4; i++) begin
                        macc[k][i] = 0; mcnt[k][i] = 0; movf[k][i] = 0;
                    end
                    mov[k] = 0; mod[k] = 0; moch[k] = 0; mocnt[k] = 0; moovf[k] = 0;
                end else begin
                    if (mov[k] && out_ready) mov[k] = 0;
                    c = int'(in_ch);
                    if (in_valid && m_rdy && c < NC[k]) begin
                        s = macc[k][c] + (longint'(in_data) & dmask);
                        o = s > amask;
                        if (o) s = (SAT[k] != 0) ? amask : s - (amask + 1);
                        if (mcnt[k][c] + 1 == 8 || in_last) begin
                            mov[k] = 1; mod[k] = s; moch[k] = c;
                            mocnt[k] = mcnt[k][c] + 1; moovf[k] = movf[k][c] | o;
                            macc[k][c] = 0; mcnt[k][c] = 0; movf[k][c] = 0;
                        end else begin
                            macc[k][c] = s; mcnt[k][c]++; movf[k][c] = movf[k][c] | o;
                        end
                    end
                    if (clr) begin
                        for (int i = 0; i < 4; i++) begin
                            macc[k][i] = 0; mcnt[k][i] = 0; movf[k][i] = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic put(input bit v, input int ch, input longint d, input bit last);
        in_valid = v;
        in_ch    = 2'(ch);
        in_data  = 32'(d);
        in_last  = last;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input longint d, input bit last);
        put(1'b1, ch, d, last);
        tick();
    endtask

    task automatic idle();
        put(1'b0, 0, 0, 1'b0);
        tick();
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; out_ready = 1'b0;
        put(1'b0, 0, 0, 1'b0);
        tick();
        tick();
        chk("rst_valid", 64'(vld0), 0);
        chk("rst_data", 64'(data0), 0);
        chk("rst_ch", 64'(ch0), 0);
        chk("rst_count", 64'(cnt0), 0);
        chk("rst_ovf", 64'(ovf0), 0);
        rst = 1'b0;
        tick();
        #1 chk("ready_after_rst", 64'(rdy0), 1);
        out_ready = 1'b1;

        // Ch0 1..8 back-to-back: automatic emit of 36.
        for (int i = 1; i <= 8; i++) send(0, i, 1'b0);
        chk("burst_valid", 64'(vld0), 1);
        chk("burst_data", 64'(data0), 36);
        chk("burst_ch", 64'(ch0), 0);
        chk("burst_count", 64'(cnt0), 8);
        chk("burst_ovf", 64'(ovf0), 0);
        idle();
        chk("valid_drop", 64'(vld0), 0);

        // Interleaved channels, early emit of ch2 via in_last.
        for (int i = 0; i < 3; i++) begin
            send(1, 5, 1'b0);
            send(2, 7, i == 2);
        end
        chk("ch2_data", 64'(data0), 21);
        chk("ch2_ch", 64'(ch0), 2);
        chk("ch2_count", 64'(cnt0), 3);
        for (int i = 0; i < 5; i++) send(1, 5, 1'b0);
        chk("ch1_data", 64'(data0), 40);
        chk("ch1_ch", 64'(ch0), 1);
        chk("ch1_count", 64'(cnt0), 8);
        chk("ch1_data_w8", 64'(data1), 40);

        // Overflow: wrap vs clamp, and sticky overflow across a burst.
        send(0, 200, 1'b0);
        send(0, 100, 1'b1);
        chk("wrap_data", 64'(data1), 44);
        chk("wrap_ovf", 64'(ovf1), 1);
        chk("clamp_data", 64'(data2), 255);
        chk("clamp_ovf", 64'(ovf2), 1);
        chk("wide_data", 64'(data0), 300);
        chk("wide_ovf", 64'(ovf0), 0);
        send(1, 200, 1'b0);
        send(1, 100, 1'b0);
        send(1, 10, 1'b1);
        chk("sticky_wrap_data", 64'(data1), 54);
        chk("sticky_wrap_ovf", 64'(ovf1), 1);
        chk("sticky_clamp_data", 64'(data2), 255);
        chk("sticky_count", 64'(cnt1), 3);
        chk("sticky_wide_data", 64'(data0), 310);

        // Backpressure: result held, input stalled, then consume + accept same cycle.
        send(0, 9, 1'b1);
        out_ready = 1'b0;
        put(1'b1, 0, 1, 1'b0);
        #1 chk("stall_ready", 64'(rdy0), 0);
        tick(); tick(); tick();
        chk("hold_valid", 64'(vld0), 1);
        chk("hold_data", 64'(data0), 9);
        chk("hold_count", 64'(cnt0), 1);
        out_ready = 1'b1;
        put(1'b1, 0, 4, 1'b1);
        #1 chk("release_ready", 64'(rdy0), 1);
        tick();
        chk("b2b_valid", 64'(vld0), 1);
        chk("b2b_data", 64'(data0), 4);
        idle();

        // Clear mid-burst on ch3 while a result is pending.
        send(3, 2, 1'b0);
        send(3, 3, 1'b0);
        send(3, 4, 1'b0);
        send(0, 11, 1'b1);
        out_ready = 1'b0;
        clr = 1'b1;
        put(1'b1, 3, 50, 1'b0);
        #1 chk("clr_ready", 64'(rdy0), 0);
        tick();
        clr = 1'b0;
        chk("clr_pending_valid", 64'(vld0), 1);
        chk("clr_pending_data", 64'(data0), 11);
        out_ready = 1'b1;
        idle();
        send(3, 6, 1'b0);
        send(3, 7, 1'b1);
        chk("post_clr_data", 64'(data0), 13);
        chk("post_clr_ch", 64'(ch0), 3);
        chk("post_clr_count", 64'(cnt0), 2);
        chk("oob_ch_no_emit", 64'(vld1), 0);

        // Reset mid-burst with a pending output.
        send(0, 1, 1'b0);
        send(0, 2, 1'b0);
        send(1, 3, 1'b1);
        out_ready = 1'b0;
        rst = 1'b1;
        put(1'b1, 0, 9, 1'b0);
        tick();
        chk("midrst_valid", 64'(vld0), 0);
        chk("midrst_data", 64'(data0), 0);
        chk("midrst_ch", 64'(ch0), 0);
        chk("midrst_count", 64'(cnt0), 0);
        chk("midrst_ovf", 64'(ovf0), 0);
        rst = 1'b0;
        out_ready = 1'b1;
        idle();
        send(0, 5, 1'b1);
        chk("after_rst_data", 64'(data0), 5);
        chk("after_rst_count", 64'(cnt0), 1);
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
